// File: rtl/simon_auto_player.sv
// Closed-loop Simon player: captures the game's LED sequence, replays it on the buttons, reports win/lose.
// Build option SIMON_AP_ERRINJ_EN adds err_inj/err_idx to replay one chosen entry with a wrong colour.
module simon_auto_player #(
  parameter int SEQ_LEN    = 4,
  parameter int PRESS_CYC  = 8,
  parameter int GAP_CYC    = 8,
  parameter int START_DLY  = 16,
  parameter int RESULT_TMO = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic [3:0] led_in,
  input  logic       win_in,
  input  logic       lose_in,
`ifdef SIMON_AP_ERRINJ_EN
  input  logic       err_inj,
  input  logic [2:0] err_idx,
`endif
  output logic [3:0] btn_out,
  output logic       busy,
  output logic       done,
  output logic       passed,
  output logic       seq_err,
  output logic [3:0] cap_cnt
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CAPTURE  = 3'd1;
  localparam logic [2:0] S_DELAY    = 3'd2;
  localparam logic [2:0] S_PRESS    = 3'd3;
  localparam logic [2:0] S_RELEASE  = 3'd4;
  localparam logic [2:0] S_WAIT_RES = 3'd5;
  localparam logic [2:0] S_ERROR    = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam logic [3:0]  SEQ_LEN_C  = 4'(SEQ_LEN);
  localparam logic [2:0]  PTR_LAST   = 3'(SEQ_LEN - 1);
  localparam logic [15:0] DLY_LAST   = 16'(START_DLY - 1);
  localparam logic [15:0] PRESS_LAST = 16'(PRESS_CYC - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);
  localparam logic [15:0] TMO_LAST   = 16'(RESULT_TMO - 1);

  logic [2:0]  state_q,   state_d;
  logic [15:0] cnt_q,     cnt_d;
  logic [2:0]  ptr_q,     ptr_d;
  logic [3:0]  cap_cnt_q, cap_cnt_d;
  logic [3:0]  led_prev_q, led_prev_d;
  logic [1:0]  mem_q [8];
  logic [1:0]  mem_d [8];
  logic [3:0]  btn_out_q, btn_out_d;
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;
  logic        passed_q,  passed_d;
  logic        seq_err_q, seq_err_d;
  logic        err_en_q,  err_en_d;
  logic [2:0]  err_pos_q, err_pos_d;

  logic        led_event;
  logic        inj_hit;
  logic [1:0]  replay_col;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  assign led_event = (led_prev_q == 4'd0) && (led_in != 4'd0);

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    cap_cnt_d  = cap_cnt_q;
    mem_d      = mem_q;
    passed_d   = passed_q;
    seq_err_d  = seq_err_q;
    err_en_d   = err_en_q;
    err_pos_d  = err_pos_q;
    led_prev_d = led_in;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          state_d   = S_CAPTURE;
          cap_cnt_d = 4'd0;
          passed_d  = 1'b0;
          seq_err_d = 1'b0;
          mem_d     = '{default: 2'b00};
`ifdef SIMON_AP_ERRINJ_EN
          err_en_d  = err_inj;
          err_pos_d = err_idx;
`else
          err_en_d  = 1'b0;
          err_pos_d = 3'd0;
`endif
        end
      end

      S_CAPTURE: begin
        // Once the sequence is full, further display-loop events are ignored until the LEDs go dark.
        if (cap_cnt_q == SEQ_LEN_C) begin
          if (led_in == 4'd0) begin
            state_d = S_DELAY;
            cnt_d   = 16'd0;
          end
        end else if (led_event) begin
          if (is_onehot(led_in)) begin
            mem_d[cap_cnt_q[2:0]] = onehot_idx(led_in);
            cap_cnt_d             = cap_cnt_q + 4'd1;
          end else begin
            seq_err_d = 1'b1;
            state_d   = S_ERROR;
          end
        end
      end

      S_DELAY: begin
        if (cnt_q == DLY_LAST) begin
          state_d = S_PRESS;
          cnt_d   = 16'd0;
          ptr_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_PRESS: begin
        if (lose_in) begin
          state_d  = S_DONE;
          passed_d = 1'b0;
        end else if (cnt_q == PRESS_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_RELEASE: begin
        if (lose_in) begin
          state_d  = S_DONE;
          passed_d = 1'b0;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = 16'd0;
          if (ptr_q == PTR_LAST) begin
            state_d = S_WAIT_RES;
          end else begin
            state_d = S_PRESS;
            ptr_d   = ptr_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_WAIT_RES: begin
        // Lose is checked first so a simultaneous win/lose reports a failure.
        if (lose_in) begin
          state_d  = S_DONE;
          passed_d = 1'b0;
        end else if (win_in) begin
          state_d  = S_DONE;
          passed_d = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          state_d   = S_DONE;
          passed_d  = 1'b0;
          seq_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_ERROR: begin
        state_d  = S_DONE;
        passed_d = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    inj_hit    = err_en_q && (ptr_d == err_pos_q);
    replay_col = mem_q[ptr_d] + {1'b0, inj_hit};
    btn_out_d  = (state_d == S_PRESS) ? (4'b0001 << replay_col) : 4'b0000;
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      ptr_q      <= 3'd0;
      cap_cnt_q  <= 4'd0;
      led_prev_q <= 4'd0;
      // NOTE: the sequence memory is small flop storage and is cleared so a replay never uses stale colours.
      mem_q      <= '{default: 2'b00};
      btn_out_q  <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      passed_q   <= 1'b0;
      seq_err_q  <= 1'b0;
      err_en_q   <= 1'b0;
      err_pos_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      cap_cnt_q  <= cap_cnt_d;
      led_prev_q <= led_prev_d;
      mem_q      <= mem_d;
      btn_out_q  <= btn_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      passed_q   <= passed_d;
      seq_err_q  <= seq_err_d;
      err_en_q   <= err_en_d;
      err_pos_q  <= err_pos_d;
    end
  end

  assign btn_out = btn_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign passed  = passed_q;
  assign seq_err = seq_err_q;
  assign cap_cnt = cap_cnt_q;

endmodule

// File: tb/tb_simon_auto_player.sv
// Bench for simon_auto_player: a Simon game model shows random colour sequences and a timeline model
// predicts every replayed button cycle, the start latency and the verdict.
`timescale 1ns/1ps
module tb_simon_auto_player;

  localparam int SEQ_LEN    = 4;
  localparam int PRESS_CYC  = 8;
  localparam int GAP_CYC    = 8;
  localparam int START_DLY  = 16;
  localparam int RESULT_TMO = 64;
  localparam int SLOT       = PRESS_CYC + GAP_CYC;
  localparam int LED_ON     = 10;
  localparam int LED_OFF    = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm;
  logic [3:0] led_in;
  logic       win_in;
  logic       lose_in;
`ifdef SIMON_AP_ERRINJ_EN
  logic       err_inj;
  logic [2:0] err_idx;
`endif
  logic [3:0] btn_out;
  logic       busy;
  logic       done;
  logic       passed;
  logic       seq_err;
  logic [3:0] cap_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] seq [SEQ_LEN];
  int inj_en  = 0;
  int inj_idx = 0;

  always #5 clk = ~clk;

  simon_auto_player #(
    .SEQ_LEN(SEQ_LEN), .PRESS_CYC(PRESS_CYC), .GAP_CYC(GAP_CYC),
    .START_DLY(START_DLY), .RESULT_TMO(RESULT_TMO)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .led_in(led_in), .win_in(win_in), .lose_in(lose_in),
`ifdef SIMON_AP_ERRINJ_EN
    .err_inj(err_inj), .err_idx(err_idx),
`endif
    .btn_out(btn_out), .busy(busy), .done(done), .passed(passed), .seq_err(seq_err),
    .cap_cnt(cap_cnt)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic show_one(input logic [1:0] c);
    led_in = 4'b0001 << c;
    repeat (LED_ON) tick();
    led_in = 4'b0000;
  endtask

  // Shows the whole sequence; returns right after the last LED is switched off (not yet sampled).
  task automatic show_seq();
    for (int i = 0; i < SEQ_LEN; i++) begin
      show_one(seq[i]);
      if (i != SEQ_LEN - 1) repeat (LED_OFF) tick();
    end
  endtask

  task automatic random_seq();
    for (int i = 0; i < SEQ_LEN; i++) seq[i] = 2'($urandom_range(0, 3));
  endtask

  // Cycles from the last LED fall until buttons first move; a stray LED blip lands in the delay window.
  task automatic wait_first_press(output int lat);
    lat = -1;
    for (int k = 1; k <= START_DLY + 40; k++) begin
      if (k == 5) led_in = 4'b0110;
      if (k == 8) led_in = 4'b0000;
      tick();
      if (btn_out != 4'b0000) begin
        lat = k;
        break;
      end
    end
    led_in = 4'b0000;
  endtask

  // Timeline model: cycle t after the first press edge -> button vector the game should see.
  function automatic logic [3:0] expected_btn(input int t);
    int slot, phase, c;
    slot  = t / SLOT;
    phase = t % SLOT;
    if (slot >= SEQ_LEN || phase >= PRESS_CYC) return 4'b0000;
    c = int'(seq[slot]);
    if (inj_en != 0 && slot == inj_idx) c = (c + 1) % 4;
    return 4'(1 << c);
  endfunction

  task automatic test_reset();
    rst = 1'b1; arm = 1'b0; led_in = 4'b0; win_in = 1'b0; lose_in = 1'b0;
`ifdef SIMON_AP_ERRINJ_EN
    err_inj = 1'b0; err_idx = 3'd0;
`endif
    repeat (2) tick();
    n_checks++;
    if ({btn_out, busy, done, passed, seq_err, cap_cnt} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got btn=%b busy=%b done=%b passed=%b seq_err=%b cap=%0d, want all 0",
               btn_out, busy, done, passed, seq_err, cap_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_replay_win(input bit use_random);
    int lat, d;
    if (use_random) random_seq();
    else begin seq[0] = 2'd2; seq[1] = 2'd0; seq[2] = 2'd3; seq[3] = 2'd1; end
    arm_pulse();
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL arm_busy: got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    show_seq();
    n_checks++;
    if (cap_cnt !== 4'(SEQ_LEN)) begin
      n_fail++; $display("FAIL cap_cnt: got %0d want %0d", cap_cnt, SEQ_LEN);
    end
    wait_first_press(lat);
    n_checks++;
    if (lat != START_DLY + 1) begin
      n_fail++; $display("FAIL start_latency: got %0d want %0d", lat, START_DLY + 1);
    end
    for (int t = 0; t < SEQ_LEN * SLOT; t++) begin
      n_checks++;
      if (btn_out !== expected_btn(t)) begin
        n_fail++; $display("FAIL replay_btn t=%0d: got %b want %b", t, btn_out, expected_btn(t));
      end
      tick();
    end
    d = $urandom_range(0, RESULT_TMO - 20);
    repeat (d) tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL wait_res: got done=%b busy=%b want done=0 busy=1", done, busy);
    end
    win_in = 1'b1;
    tick();
    win_in = 1'b0;
    n_checks++;
    if ({done, passed, seq_err, busy, btn_out} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'b0}) begin
      n_fail++;
      $display("FAIL win_verdict: got done=%b passed=%b seq_err=%b busy=%b btn=%b want 1 1 0 0 0000",
               done, passed, seq_err, busy, btn_out);
    end
  endtask

  task automatic test_timeout();
    int lat;
    random_seq();
    arm_pulse();
    show_seq();
    wait_first_press(lat);
    for (int t = 0; t < SEQ_LEN * SLOT; t++) begin
      n_checks++;
      if (btn_out !== expected_btn(t)) begin
        n_fail++; $display("FAIL tmo_replay t=%0d: got %b want %b", t, btn_out, expected_btn(t));
      end
      tick();
    end
    repeat (RESULT_TMO - 1) tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL tmo_early: got done=%b want 0 one cycle before timeout", done);
    end
    tick();
    n_checks++;
    if ({done, seq_err, passed} !== 3'b110) begin
      n_fail++; $display("FAIL tmo_verdict: got done=%b seq_err=%b passed=%b want 1 1 0", done, seq_err, passed);
    end
  endtask

  task automatic test_bad_led();
    random_seq();
    arm_pulse();
    n_checks++;
    if ({seq_err, done, passed, cap_cnt, busy} !== {3'b000, 4'd0, 1'b1}) begin
      n_fail++; $display("FAIL rearm_clear: got seq_err=%b done=%b passed=%b cap=%0d busy=%b want 0 0 0 0 1",
                         seq_err, done, passed, cap_cnt, busy);
    end
    show_one(seq[0]);
    repeat (LED_OFF) tick();
    led_in = 4'b0110;
    tick();
    n_checks++;
    if ({seq_err, busy, done, btn_out} !== {3'b110, 4'b0}) begin
      n_fail++; $display("FAIL bad_led_error: got seq_err=%b busy=%b done=%b btn=%b want 1 1 0 0000",
                         seq_err, busy, done, btn_out);
    end
    led_in = 4'b0000;
    tick();
    n_checks++;
    if ({done, passed, seq_err, busy, btn_out, cap_cnt} !== {4'b1010, 4'b0, 4'd1}) begin
      n_fail++; $display("FAIL bad_led_done: got done=%b passed=%b seq_err=%b busy=%b btn=%b cap=%0d want 1 0 1 0 0000 1",
                         done, passed, seq_err, busy, btn_out, cap_cnt);
    end
  endtask

  task automatic test_lose_mid_press();
    int lat;
    random_seq();
    arm_pulse();
    show_seq();
    wait_first_press(lat);
    repeat (SLOT + 3) tick();
    n_checks++;
    if (btn_out !== expected_btn(SLOT + 3)) begin
      n_fail++; $display("FAIL second_press: got %b want %b", btn_out, expected_btn(SLOT + 3));
    end
    lose_in = 1'b1;
    tick();
    lose_in = 1'b0;
    n_checks++;
    if ({btn_out, done, passed, busy, seq_err} !== {4'b0, 4'b1000}) begin
      n_fail++; $display("FAIL lose_abort: got btn=%b done=%b passed=%b busy=%b seq_err=%b want 0000 1 0 0 0",
                         btn_out, done, passed, busy, seq_err);
    end
  endtask

  task automatic test_reset_mid_press();
    int lat;
    random_seq();
    arm_pulse();
    show_seq();
    wait_first_press(lat);
    repeat (3) tick();
    n_checks++;
    if (btn_out !== expected_btn(3)) begin
      n_fail++; $display("FAIL pre_reset_press: got %b want %b", btn_out, expected_btn(3));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({btn_out, busy, done, passed, seq_err, cap_cnt} !== 12'd0) begin
      n_fail++; $display("FAIL reset_mid_press: got btn=%b busy=%b done=%b passed=%b seq_err=%b cap=%0d want all 0",
                         btn_out, busy, done, passed, seq_err, cap_cnt);
    end
  endtask

  task automatic test_arm_while_busy();
    int lat;
    random_seq();
    arm_pulse();
    show_one(seq[0]);
    repeat (LED_OFF) tick();
    show_one(seq[1]);
    arm_pulse();
    n_checks++;
    if (cap_cnt !== 4'd2 || busy !== 1'b1) begin
      n_fail++; $display("FAIL arm_ignored_capture: got cap=%0d busy=%b want 2 1", cap_cnt, busy);
    end
    repeat (LED_OFF - 1) tick();
    show_one(seq[2]);
    repeat (LED_OFF) tick();
    show_one(seq[3]);
    wait_first_press(lat);
    n_checks++;
    if (lat != START_DLY + 1) begin
      n_fail++; $display("FAIL busy_latency: got %0d want %0d", lat, START_DLY + 1);
    end
    for (int t = 0; t < SEQ_LEN * SLOT; t++) begin
      n_checks++;
      if (btn_out !== expected_btn(t)) begin
        n_fail++; $display("FAIL busy_replay t=%0d: got %b want %b", t, btn_out, expected_btn(t));
      end
      tick();
    end
    arm_pulse();
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || cap_cnt !== 4'(SEQ_LEN)) begin
      n_fail++; $display("FAIL arm_ignored_wait: got busy=%b done=%b cap=%0d want 1 0 %0d",
                         busy, done, cap_cnt, SEQ_LEN);
    end
    win_in  = 1'b1;
    lose_in = 1'b1;
    tick();
    win_in  = 1'b0;
    lose_in = 1'b0;
    n_checks++;
    if (done !== 1'b1 || passed !== 1'b0) begin
      n_fail++; $display("FAIL win_lose_tie: got done=%b passed=%b want 1 0", done, passed);
    end
  endtask

`ifdef SIMON_AP_ERRINJ_EN
  task automatic test_errinj();
    int lat;
    seq[0] = 2'd2; seq[1] = 2'd3; seq[2] = 2'd1; seq[3] = 2'd0;
    inj_en = 1; inj_idx = 1;
    err_inj = 1'b1; err_idx = 3'd1;
    arm_pulse();
    err_inj = 1'b0; err_idx = 3'd0;
    show_seq();
    wait_first_press(lat);
    for (int t = 0; t < SEQ_LEN * SLOT; t++) begin
      n_checks++;
      if (btn_out !== expected_btn(t)) begin
        n_fail++; $display("FAIL errinj_replay t=%0d: got %b want %b", t, btn_out, expected_btn(t));
      end
      tick();
    end
    lose_in = 1'b1;
    tick();
    lose_in = 1'b0;
    n_checks++;
    if (done !== 1'b1 || passed !== 1'b0) begin
      n_fail++; $display("FAIL errinj_verdict: got done=%b passed=%b want 1 0", done, passed);
    end
    inj_en = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_replay_win(1'b0);
    test_replay_win(1'b1);
    test_replay_win(1'b1);
    test_timeout();
    test_bad_led();
    test_lose_mid_press();
    test_reset_mid_press();
    test_arm_while_busy();
`ifdef SIMON_AP_ERRINJ_EN
    test_errinj();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
